// File: rtl/packetizer.sv
// packetizer: transmit-side framer that wraps each 16-bit input word into one
// 48-bit flit for the flit link, tagging the tail flit with 16'hFFFF.
// Latency 1 cycle (single output register), throughput 1 word/cycle.
// Backpressure: data_ready = !flit_valid || flit_ready; a stalled flit holds stable.
//
// Ports:
//   clk, reset          clock (rising edge), asynchronous active-high reset
//   data_in/_valid/_last/data_ready   16-bit word input with valid/ready/last
//   flitout/flit_valid/flit_ready     48-bit flit output with valid/ready
//   trunc               1-cycle pulse aligned with a tail forced by MAX_LEN
//
// Parameters: SRC_ID, DEST_ID, MAX_LEN (2..256).
// Optional feature: define PACKETIZER_CHECKSUM_EN to place a running XOR of the
// packet's data words in the tail flit's [15:0] instead of {SRC_ID, pkt_num}.

module packetizer #(
    parameter logic [7:0] SRC_ID  = 8'h01,
    parameter logic [3:0] DEST_ID = 4'h2,
    parameter int         MAX_LEN = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] data_in,
    input  logic        data_valid,
    input  logic        data_last,
    output logic        data_ready,
    output logic [47:0] flitout,
    output logic        flit_valid,
    input  logic        flit_ready,
    output logic        trunc
);

    typedef enum logic {
        IDLE = 1'b0,
        BODY = 1'b1
    } state_t;

    // Word index at which a tail is forced regardless of data_last.
    localparam logic [7:0] LAST_SEQ = 8'(MAX_LEN - 1);

    state_t      state_q;
    logic [7:0]  seq_q;
    logic [7:0]  pkt_num_q;
    logic [47:0] flit_q;
    logic        vld_q;
    logic        trunc_q;
`ifdef PACKETIZER_CHECKSUM_EN
    logic [15:0] csum_q;
`endif

    logic        accept;
    logic        at_max;
    logic        is_tail;
    logic [15:0] tag_d;
    logic [15:0] low_d;
    logic [47:0] flit_d;

    assign data_ready = !vld_q || flit_ready;
    assign accept     = data_valid && data_ready;

    assign flitout    = flit_q;
    assign flit_valid = vld_q;
    assign trunc      = trunc_q;

    // Flit contents for the word being offered this cycle.
    always_comb begin
        at_max  = (seq_q == LAST_SEQ);
        is_tail = data_last || at_max;
        // Head/body tags start with 4'hA/4'hB, so they can never alias 16'hFFFF.
        tag_d   = is_tail ? 16'hFFFF
                          : {(state_q == IDLE) ? 4'hA : 4'hB, DEST_ID, seq_q};
        low_d   = {SRC_ID, pkt_num_q};
`ifdef PACKETIZER_CHECKSUM_EN
        // The tail's own word is folded into the checksum it carries.
        if (is_tail) begin
            low_d = csum_q ^ data_in;
        end
`endif
        flit_d  = {tag_d, data_in, low_d};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            seq_q     <= 8'h00;
            pkt_num_q <= 8'h00;
            flit_q    <= 48'h0;
            vld_q     <= 1'b0;
            trunc_q   <= 1'b0;
`ifdef PACKETIZER_CHECKSUM_EN
            csum_q    <= 16'h0000;
`endif
        end else begin
            // trunc is only ever high on the first cycle a forced tail is shown.
            trunc_q <= 1'b0;
            if (accept) begin
                flit_q  <= flit_d;
                vld_q   <= 1'b1;
                trunc_q <= at_max && !data_last;
                if (is_tail) begin
                    state_q   <= IDLE;
                    seq_q     <= 8'h00;
                    pkt_num_q <= pkt_num_q + 8'h01;
`ifdef PACKETIZER_CHECKSUM_EN
                    csum_q    <= 16'h0000;
`endif
                end else begin
                    state_q   <= BODY;
                    seq_q     <= seq_q + 8'h01;
`ifdef PACKETIZER_CHECKSUM_EN
                    csum_q    <= csum_q ^ data_in;
`endif
                end
            end else if (flit_ready || !vld_q) begin
                // Nothing new to show: blank the link so no stale tail tag lingers.
                flit_q <= 48'h0;
                vld_q  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_packetizer.sv
module tb_packetizer;

    localparam int ML = 4;
`ifdef PACKETIZER_CHECKSUM_EN
    localparam bit CS = 1'b1;
`else
    localparam bit CS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] data_in = 16'h0;
    logic        data_valid = 1'b0;
    logic        data_last = 1'b0;
    logic        data_ready;
    logic [47:0] flitout;
    logic        flit_valid;
    logic        flit_ready = 1'b1;
    logic        trunc;

    packetizer #(
        .SRC_ID (8'h01),
        .DEST_ID(4'h2),
        .MAX_LEN(ML)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .data_in   (data_in),
        .data_valid(data_valid),
        .data_last (data_last),
        .data_ready(data_ready),
        .flitout   (flitout),
        .flit_valid(flit_valid),
        .flit_ready(flit_ready),
        .trunc     (trunc)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [47:0] flit;
        logic        tr;
    } exp_t;

    exp_t        sb[$];
    int          errors = 0;
    int          checks = 0;
    bit          acc_f = 1'b0;
    bit          hold_f = 1'b0;
    bit          m_vld = 1'b0;
    logic [47:0] last_exp = 48'h0;

    // Reference model state: word index within packet, packet number, XOR.
    int          m_idx = 0;
    logic [7:0]  m_pkt = 8'h00;
    logic [15:0] m_x = 16'h0;

    task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t lit(input logic [47:0] f, input logic t);
        exp_t e;
        e.flit = f;
        e.tr   = t;
        return e;
    endfunction

    task automatic model_step(input logic [15:0] d, input logic l, output exp_t e);
        bit          tail;
        logic [15:0] tag;
        logic [15:0] low;
        tail = l || (m_idx == ML - 1);
        tag  = tail ? 16'hFFFF : {(m_idx == 0) ? 4'hA : 4'hB, 4'h2, 8'(m_idx)};
        low  = {8'h01, m_pkt};
        m_x  = m_x ^ d;
        if (CS && tail) low = m_x;
        e.flit = {tag, d, low};
        e.tr   = tail && !l;
        if (tail) begin
            m_idx = 0;
            m_pkt = m_pkt + 8'h01;
            m_x   = 16'h0;
        end else begin
            m_idx = m_idx + 1;
        end
    endtask

    // One clock of stimulus. Drives at the falling edge, then records what the
    // coming rising edge must do for the monitor.
    task automatic cycle(input bit v, input logic [15:0] d, input bit l, input bit fr,
                         input bit use_lit, input exp_t lv, output bit acc);
        exp_t e;
        @(negedge clk);
        data_valid = v;
        data_in    = d;
        data_last  = l;
        flit_ready = fr;
        #1;
        chk("data_ready", {47'h0, data_ready}, {47'h0, (!m_vld || fr)});
        acc    = v && data_ready;
        acc_f  = acc;
        hold_f = m_vld && !fr;
        if (acc) begin
            model_step(d, l, e);
            if (use_lit) e = lv;
            sb.push_back(e);
        end
    endtask

    task automatic send(input logic [15:0] d, input bit l, input int stall, input exp_t lv);
        bit acc;
        int n;
        acc = 1'b0;
        for (int i = 0; i < stall && !acc; i++) cycle(1'b1, d, l, 1'b0, 1'b1, lv, acc);
        n = 0;
        while (!acc && n < 50) begin
            cycle(1'b1, d, l, 1'b1, 1'b1, lv, acc);
            n++;
        end
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: word %h never accepted", d);
        end
    endtask

    task automatic idle_cycle();
        bit acc;
        cycle(1'b0, 16'h0, 1'b0, 1'b1, 1'b0, '0, acc);
    endtask

    // Monitor: checks the output register one step after each rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (!reset) begin
                if (acc_f) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL sb_empty: got flit %h with nothing expected", flitout);
                    end else begin
                        e = sb.pop_front();
                        chk("flit", flitout, e.flit);
                        chk("trunc", {47'h0, trunc}, {47'h0, e.tr});
                        chk("flit_valid", {47'h0, flit_valid}, 48'h1);
                        last_exp = e.flit;
                    end
                    m_vld = 1'b1;
                end else if (hold_f) begin
                    chk("hold_flit", flitout, last_exp);
                    chk("hold_valid", {47'h0, flit_valid}, 48'h1);
                    chk("hold_trunc", {47'h0, trunc}, 48'h0);
                    m_vld = 1'b1;
                end else begin
                    chk("idle_flit", flitout, 48'h0);
                    chk("idle_valid", {47'h0, flit_valid}, 48'h0);
                    chk("idle_trunc", {47'h0, trunc}, 48'h0);
                    m_vld = 1'b0;
                end
            end
        end
    end

    initial begin
        bit acc;
        // Reset state.
        #2;
        chk("rst_flit", flitout, 48'h0);
        chk("rst_valid", {47'h0, flit_valid}, 48'h0);
        chk("rst_trunc", {47'h0, trunc}, 48'h0);
        chk("rst_ready", {47'h0, data_ready}, 48'h1);
        @(negedge clk);
        reset = 1'b0;

        // Three-word packet.
        send(16'h1111, 1'b0, 0, lit(48'hA200_1111_0100, 1'b0));
        send(16'h2222, 1'b0, 0, lit(48'hB201_2222_0100, 1'b0));
        send(16'h3333, 1'b1, 0, lit(CS ? 48'hFFFF_3333_0000 : 48'hFFFF_3333_0100, 1'b0));
        idle_cycle();
        idle_cycle();

        // Single-word packet as packet 1.
        send(16'hABCD, 1'b1, 0, lit(CS ? 48'hFFFF_ABCD_ABCD : 48'hFFFF_ABCD_0101, 1'b0));
        idle_cycle();

        // Checksum pattern with a 3-cycle downstream stall mid-packet.
        send(16'h000F, 1'b0, 0, lit(48'hA200_000F_0102, 1'b0));
        send(16'h00F0, 1'b0, 3, lit(48'hB201_00F0_0102, 1'b0));
        send(16'h0F00, 1'b1, 0, lit(CS ? 48'hFFFF_0F00_0FFF : 48'hFFFF_0F00_0102, 1'b0));
        idle_cycle();

        // Six words with MAX_LEN=4: truncation then a fresh packet.
        send(16'h0001, 1'b0, 0, lit(48'hA200_0001_0103, 1'b0));
        send(16'h0002, 1'b0, 0, lit(48'hB201_0002_0103, 1'b0));
        send(16'h0003, 1'b0, 0, lit(48'hB202_0003_0103, 1'b0));
        send(16'h0004, 1'b0, 0, lit(CS ? 48'hFFFF_0004_0004 : 48'hFFFF_0004_0103, 1'b1));
        send(16'h0005, 1'b0, 0, lit(48'hA200_0005_0104, 1'b0));
        send(16'h0006, 1'b1, 0, lit(CS ? 48'hFFFF_0006_0003 : 48'hFFFF_0006_0104, 1'b0));
        idle_cycle();

        // Randomized traffic with random backpressure, checked against the model.
        for (int i = 0; i < 600; i++) begin
            cycle($urandom_range(0, 9) < 7, 16'($urandom), $urandom_range(0, 3) == 0,
                  $urandom_range(0, 3) != 0, 1'b0, '0, acc);
        end
        idle_cycle();

        // Asynchronous reset mid-packet.
        cycle(1'b1, 16'h1234, 1'b0, 1'b1, 1'b0, '0, acc);
        cycle(1'b1, 16'h5678, 1'b0, 1'b1, 1'b0, '0, acc);
        @(negedge clk);
        data_valid = 1'b0;
        #3;
        reset = 1'b1;
        #1;
        chk("arst_flit", flitout, 48'h0);
        chk("arst_valid", {47'h0, flit_valid}, 48'h0);
        chk("arst_trunc", {47'h0, trunc}, 48'h0);
        sb.delete();
        acc_f  = 1'b0;
        hold_f = 1'b0;
        m_vld  = 1'b0;
        m_idx  = 0;
        m_pkt  = 8'h00;
        m_x    = 16'h0;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // First packet after reset restarts with an A head and pkt_num 00.
        send(16'h5555, 1'b0, 0, lit(48'hA200_5555_0100, 1'b0));
        send(16'h6666, 1'b1, 0, lit(CS ? 48'hFFFF_6666_3333 : 48'hFFFF_6666_0100, 1'b0));

        repeat (3) idle_cycle();
        @(negedge clk);
        chk("sb_drained", 48'(sb.size()), 48'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
